// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN          address / instruction width
//   RESET_PC      reset value of the internal fetch address
//   NOP_INSTR     instruction presented to decode when nothing is valid
//   fetch_entry_t one {pc, instr} FIFO record
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of every non-clock/reset signal of fetch_stage.
//   master : the fetch stage (drives imem request, decode-side outputs, pc_advance, fault)
//   slave  : the environment (program_counter, instruction memory, decode)
interface fetch_if;
  import fetch_pkg::*;

  // program_counter side
  logic [XLEN-1:0] pc_in;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            pc_advance;
  // instruction memory side
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  // decode side
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            id_ready;
  // status
  logic            fetch_fault;

  modport master (
    input  pc_in, redirect, redirect_addr, imem_ack, imem_rvalid, imem_rdata, id_ready,
    output pc_advance, imem_req, imem_addr, id_valid, id_pc, id_instr, fetch_fault
  );

  modport slave (
    output pc_in, redirect, redirect_addr, imem_ack, imem_rvalid, imem_rdata, id_ready,
    input  pc_advance, imem_req, imem_addr, id_valid, id_pc, id_instr, fetch_fault
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} records.
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, wdata_i  write request and data
//   pop_i            consume head
//   flush_i          discard all entries (wins over push and pop)
//   rdata_o          head entry (valid while empty_o is low)
//   count_o, full_o, empty_o  occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    pop_en  = pop_i & ~empty_o & ~flush_i;
    // A full FIFO may still accept a write when the head leaves in the same cycle.
    push_en = push_i & (~full_o | pop_en) & ~flush_i;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) wptr_d = wptr_q + PtrW'(1);
      if (pop_en)  rptr_d = rptr_q + PtrW'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage between program_counter and decode.
//   clock, reset  single clock, synchronous active-high reset
//   bus           fetch_if.master: pc_in/redirect/redirect_addr/pc_advance towards the PC,
//                 imem_req/addr/ack/rvalid/rdata towards memory,
//                 id_valid/pc/instr/ready towards decode, sticky fetch_fault.
// One memory request in flight at a time; FIFO space is reserved at issue so a
// response can always be pushed. A redirect flushes the FIFO and kills any
// response still in flight.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic   clock,
  input logic   reset,
  fetch_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            outstanding_q, outstanding_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            fault_q, fault_d;

  logic            misaligned;
  logic            handshake;
  logic            resp;
  logic            push, pop;
  logic [CntW:0]   inflight;
  fetch_entry_t    wr_entry, rd_entry;
  logic [2*XLEN-1:0] fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .flush_i (bus.redirect),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    misaligned = is_misaligned(bus.pc_in);
    // Entries held plus the one being fetched must leave room for its response.
    inflight   = {1'b0, fifo_count} + (CntW + 1)'(outstanding_q);

    bus.imem_req  = ~reset & ~outstanding_q & ~fifo_full & (inflight < (CntW + 1)'(DEPTH)) &
                    ~bus.redirect & ~misaligned;
    bus.imem_addr = {bus.pc_in[XLEN-1:2], 2'b00};
    handshake     = bus.imem_req & bus.imem_ack;
    bus.pc_advance = handshake;

    resp = bus.imem_rvalid & outstanding_q;
    push = resp & ~kill_q & ~bus.redirect;

    bus.id_valid = ~fifo_empty;
    rd_entry     = fetch_entry_t'(fifo_rdata);
    bus.id_pc    = rd_entry.pc;
    bus.id_instr = bus.id_valid ? rd_entry.instr : NOP_INSTR;
    pop          = bus.id_valid & bus.id_ready & ~bus.redirect;

    wr_entry.pc    = addr_q;
    wr_entry.instr = bus.imem_rdata;

    bus.fetch_fault = fault_q;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    addr_d        = addr_q;
    fault_d       = fault_q | misaligned;

    if (resp) begin
      outstanding_d = 1'b0;
      kill_d        = 1'b0;
    end else if (bus.redirect && outstanding_q) begin
      kill_d = 1'b1;
    end

    // Track the branch target; any in-flight response is killed so this never
    // labels a pushed entry, and the next handshake overwrites it.
    if (bus.redirect) addr_d = {bus.redirect_addr[XLEN-1:2], 2'b00};

    if (handshake) begin
      outstanding_d = 1'b1;
      addr_d        = bus.imem_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
      addr_q        <= RESET_PC;
      fault_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      addr_q        <= addr_d;
      fault_q       <= fault_d;
    end
  end

endmodule
